rsa_decrypt: RTL and testbench

- Receiver-side counterpart of the team's RSA encryptor: recovers plaintext from a 32-bit ciphertext.
- Computes message = (cipher^d mod n) * unblind mod n.
- `unblind` is the modular inverse of the encryptor's fixed 85738 premultiplier, precomputed by software.
- All modular products use a bit-serial shift-add multiplier, so no wide `%` operator is inferred.
- Sits on the receive path beside the encryptor, driven by a start/done handshake.

---
 rtl/rsa_pkg.sv | 23 ++
 rtl/rsa_modmul.sv | 75 +++++++
 rtl/rsa_decrypt.sv | 203 ++++++++++++++++++++
 tb/tb_rsa_decrypt.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rsa_pkg.sv
// Shared constants and state encodings for the RSA receive path.
package rsa_pkg;

    localparam int RSA_W = 32;

    // Premultiplier applied by the encryptor; software inverts it mod n.
    localparam logic [RSA_W-1:0] RSA_BLIND = 32'd85738;

    typedef enum logic [2:0] {
        IDLE,
        REDUCE,
        EXP,
        UNBLIND,
        FINISH
    } rsa_state_t;

    typedef enum logic [1:0] {
        MM_IDLE,
        MM_RUN,
        MM_CAP
    } mm_phase_t;

endpackage

// File: rtl/rsa_modmul.sv
// Bit-serial (a * b) mod n, MSB-first over a; requires b < n.
module rsa_modmul
    import rsa_pkg::*;
#(
    parameter int W = RSA_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] n,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] p
);

    localparam int CW = $clog2(W + 1);

    mm_phase_t      ph;
    logic [W-1:0]   a_r;
    logic [W+1:0]   b_r;
    logic [W+1:0]   n_r;
    logic [W+1:0]   r;
    logic [CW-1:0]  cnt;
    logic [W+1:0]   r2;
    logic [W+1:0]   t1;
    logic [W+1:0]   t2;

    // r < n before each step, so 2r + b < 3n fits in W+2 bits.
    always_comb begin
        r2 = (r << 1) + (a_r[W-1] ? b_r : '0);
        t1 = (r2 >= n_r) ? r2 - n_r : r2;
        t2 = (t1 >= n_r) ? t1 - n_r : t1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ph  <= MM_IDLE;
            a_r <= '0;
            b_r <= '0;
            n_r <= '0;
            r   <= '0;
            cnt <= '0;
        end else begin
            unique case (ph)
                MM_IDLE: begin
                    if (start) begin
                        a_r <= a;
                        b_r <= {2'b00, b};
                        n_r <= {2'b00, n};
                        r   <= '0;
                        cnt <= CW'(W);
                        ph  <= MM_RUN;
                    end
                end
                MM_RUN: begin
                    r   <= t2;
                    a_r <= a_r << 1;
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        ph <= MM_CAP;
                    end
                end
                MM_CAP: ph <= MM_IDLE;
                default: ph <= MM_IDLE;
            endcase
        end
    end

    assign busy = (ph != MM_IDLE);
    assign done = (ph == MM_CAP);
    assign p    = r[W-1:0];

endmodule

// File: rtl/rsa_decrypt.sv
// RSA receive path: message = (cipher^d mod n) * unblind mod n.
module rsa_decrypt
    import rsa_pkg::*;
#(
    parameter int W = RSA_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] cipher,
    input  logic [W-1:0] d,
    input  logic [W-1:0] n,
    input  logic [W-1:0] unblind,
    output logic [W-1:0] message,
    output logic         done,
    output logic         busy,
    output logic         error
);

    rsa_state_t   state;
    rsa_state_t   nstate;

    logic [W-1:0] c_r;
    logic [W-1:0] e_r;
    logic [W-1:0] n_r;
    logic [W-1:0] u_r;
    logic [W-1:0] base;
    logic [W-1:0] result;
    logic         go;
    logic         go_n;

    logic         a_start;
    logic         a_busy;
    logic         a_done;
    logic [W-1:0] a_a;
    logic [W-1:0] a_b;
    logic [W-1:0] a_p;
    logic         b_start;
    logic         b_busy;
    logic         b_done;
    logic [W-1:0] b_p;

    logic         accept;
    logic         step_done;
    logic         bad;

    assign accept = (state == IDLE) && start && !busy
                    && !a_busy && !b_busy;
    assign step_done = a_done && ((state != EXP) || b_done);
    assign bad = (n_r < W'(2));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nstate;
        end
    end

    always_comb begin
        nstate = state;
        go_n   = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    if (n < W'(2)) begin
                        nstate = FINISH;
                    end else begin
                        nstate = REDUCE;
                        go_n   = 1'b1;
                    end
                end
            end
            REDUCE: begin
                if (step_done) begin
                    go_n   = 1'b1;
                    nstate = (e_r == '0) ? UNBLIND : EXP;
                end
            end
            EXP: begin
                if (step_done) begin
                    go_n   = 1'b1;
                    nstate = (e_r[W-1:1] == '0) ? UNBLIND : EXP;
                end
            end
            UNBLIND: begin
                if (step_done) begin
                    nstate = FINISH;
                end
            end
            FINISH: nstate = IDLE;
            default: nstate = IDLE;
        endcase
    end

    // Instance A serves every step; B only squares the base in EXP.
    always_comb begin
        a_start = go;
        b_start = go && (state == EXP);
        a_a     = '0;
        a_b     = '0;
        unique case (state)
            REDUCE: begin
                a_a = c_r;
                a_b = W'(1);
            end
            EXP: begin
                a_a = result;
                a_b = base;
            end
            UNBLIND: begin
                a_a = u_r;
                a_b = result;
            end
            default: begin
                a_a = '0;
                a_b = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            c_r     <= '0;
            e_r     <= '0;
            n_r     <= '0;
            u_r     <= '0;
            base    <= '0;
            result  <= '0;
            go      <= 1'b0;
            message <= '0;
            done    <= 1'b0;
            busy    <= 1'b0;
            error   <= 1'b0;
        end else begin
            go   <= go_n;
            done <= (state == FINISH);
            if (done) begin
                busy <= 1'b0;
            end
            if (accept) begin
                c_r   <= cipher;
                e_r   <= d;
                n_r   <= n;
                u_r   <= unblind;
                error <= 1'b0;
                busy  <= 1'b1;
            end
            unique case (state)
                REDUCE: begin
                    if (step_done) begin
                        base   <= a_p;
                        result <= W'(1);
                    end
                end
                EXP: begin
                    if (step_done) begin
                        if (e_r[0]) begin
                            result <= a_p;
                        end
                        base <= b_p;
                        e_r  <= e_r >> 1;
                    end
                end
                UNBLIND: begin
                    if (step_done) begin
                        result <= a_p;
                    end
                end
                FINISH: begin
                    message <= bad ? '0 : result;
                    error   <= bad;
                end
                default: ;
            endcase
        end
    end

    rsa_modmul #(.W(W)) u_mm_a (
        .clk   (clk),
        .reset (reset),
        .start (a_start),
        .a     (a_a),
        .b     (a_b),
        .n     (n_r),
        .busy  (a_busy),
        .done  (a_done),
        .p     (a_p)
    );

    rsa_modmul #(.W(W)) u_mm_b (
        .clk   (clk),
        .reset (reset),
        .start (b_start),
        .a     (base),
        .b     (base),
        .n     (n_r),
        .busy  (b_busy),
        .done  (b_done),
        .p     (b_p)
    );

endmodule

// File: tb/tb_rsa_decrypt.sv
// Self-checking bench for rsa_decrypt: vector table plus handshake/reset sequences.
module tb_rsa_decrypt;

    localparam int W = 32;

    logic         clk;
    logic         reset;
    logic         start;
    logic [W-1:0] cipher;
    logic [W-1:0] d;
    logic [W-1:0] n;
    logic [W-1:0] unblind;
    logic [W-1:0] message;
    logic         done;
    logic         busy;
    logic         error;

    rsa_decrypt #(.W(W)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .cipher  (cipher),
        .d       (d),
        .n       (n),
        .unblind (unblind),
        .message (message),
        .done    (done),
        .busy    (busy),
        .error   (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] c;
        logic [W-1:0] d;
        logic [W-1:0] n;
        logic [W-1:0] u;
        logic [W-1:0] msg;
        bit           err;
        int           lat;
    } vec_t;

    typedef struct {
        logic [W-1:0] msg;
        bit           err;
        int           lat;
        int           t0;
        string        name;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[9];
    int   nchk;
    int   nerr;
    int   ndone;
    int   cyc;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference: plain 64-bit modular exponentiation.
    function automatic logic [W-1:0] ref_msg(input logic [W-1:0] c,
        input logic [W-1:0] e, input logic [W-1:0] m, input logic [W-1:0] u);
        logic [63:0] mm, r, b;
        logic [W-1:0] x;
        if (m < 2) return '0;
        mm = {32'd0, m};
        r  = 64'd1;
        b  = {32'd0, c} % mm;
        x  = e;
        while (x != 0) begin
            if (x[0]) r = (r * b) % mm;
            b = (b * b) % mm;
            x = x >> 1;
        end
        r = (({32'd0, u} % mm) * r) % mm;
        return r[W-1:0];
    endfunction

    // Edges from the start-sampling edge to the edge that raises done.
    function automatic int ref_lat(input logic [W-1:0] e,
                                   input logic [W-1:0] m);
        int l;
        if (m < 2) return 1;
        l = 0;
        for (int i = 0; i < W; i++) if (e[i]) l = i + 1;
        return 1 + (l + 2) * (W + 2);
    endfunction

    always @(negedge clk) begin
        if (!reset && done) begin
            exp_t e;
            ndone++;
            if (sb.size() == 0) begin
                nchk++;
                nerr++;
                $display("FAIL stray_done: got done=1 expected none at cycle %0d", cyc);
            end else begin
                e = sb.pop_front();
                check({e.name, " msg"}, 64'(message), 64'(e.msg));
                check({e.name, " err"}, 64'(error), 64'(e.err));
                check({e.name, " lat"}, 64'(cyc - e.t0), 64'(e.lat));
            end
        end
    end

    task automatic wait_idle();
        int k;
        for (k = 0; k < 3000 && busy; k++) @(negedge clk);
        if (busy) begin
            nchk++;
            nerr++;
            $display("FAIL idle_timeout: got busy=1 expected 0");
        end
    endtask

    task automatic drain();
        int k;
        for (k = 0; k < 3000 && sb.size() != 0; k++) @(negedge clk);
        @(negedge clk);
        if (sb.size() != 0) begin
            nchk++;
            nerr++;
            $display("FAIL done_timeout: got %0d pending expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic launch(input vec_t v, input string nm);
        exp_t e;
        wait_idle();
        @(negedge clk);
        cipher  = v.c;
        d       = v.d;
        n       = v.n;
        unblind = v.u;
        start   = 1'b1;
        e.msg  = v.msg;
        e.err  = v.err;
        e.lat  = v.lat;
        e.t0   = cyc + 1;
        e.name = nm;
        sb.push_back(e);
        @(negedge clk);
        start   = 1'b0;
        cipher  = $urandom;
        d       = $urandom;
        n       = $urandom;
        unblind = $urandom;
        check({nm, " busy_after_start"}, 64'(busy), 64'd1);
        check({nm, " error_cleared"}, 64'(error), 64'd0);
    endtask

    function automatic vec_t mk(input logic [W-1:0] c, input logic [W-1:0] e,
                                input logic [W-1:0] m, input logic [W-1:0] u);
        vec_t v;
        v.c   = c;
        v.d   = e;
        v.n   = m;
        v.u   = u;
        v.msg = ref_msg(c, e, m, u);
        v.err = (m < 2);
        v.lat = ref_lat(e, m);
        return v;
    endfunction

    initial begin
        int nd0;
        vec_t v;
        nchk    = 0;
        nerr    = 0;
        ndone   = 0;
        reset   = 1'b1;
        start   = 1'b0;
        cipher  = '0;
        d       = '0;
        n       = '0;
        unblind = '0;

        tbl[0] = '{32'd2790, 32'd2753, 32'd3233, 32'd1, 32'd65, 1'b0, 477};
        tbl[1] = '{32'd2790, 32'd2753, 32'd3233, 32'd2, 32'd130, 1'b0, 477};
        tbl[2] = '{32'd6023, 32'd2753, 32'd3233, 32'd1, 32'd65, 1'b0, 477};
        tbl[3] = '{32'd5, 32'd0, 32'd3233, 32'd7, 32'd7, 1'b0, 69};
        tbl[4] = '{32'd5, 32'd2753, 32'd1, 32'd3, 32'd0, 1'b1, 1};
        tbl[5] = '{32'd5, 32'd7, 32'd0, 32'd3, 32'd0, 1'b1, 1};
        tbl[6] = mk(32'd5, 32'd3, 32'd2, 32'd1);
        tbl[7] = mk(32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFB, 32'hFFFF_FFFF);
        tbl[8] = mk(32'h1234_5678, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 32'd85738);

        repeat (3) @(negedge clk);
        check("reset message", 64'(message), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        check("reset error", 64'(error), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            launch(tbl[i], $sformatf("vec%0d", i));
            drain();
        end
        repeat (3) @(negedge clk);
        check("message_held", 64'(message), 64'(tbl[8].msg));

        // Second start while busy must be ignored.
        nd0 = ndone;
        launch(tbl[1], "busy_start");
        repeat (50) @(negedge clk);
        v = mk(32'd9, 32'd3, 32'd1, 32'd1);
        cipher = v.c;
        n      = v.n;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_start still_busy", 64'(busy), 64'd1);
        drain();
        repeat (40) @(negedge clk);
        check("busy_start done_count", 64'(ndone - nd0), 64'd1);

        // Reset in the middle of EXP aborts the run.
        launch(tbl[0], "abort");
        repeat (200) @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort done", 64'(done), 64'd0);
        check("abort busy", 64'(busy), 64'd0);
        check("abort message", 64'(message), 64'd0);
        sb.delete();
        nd0 = ndone;
        @(negedge clk);
        reset = 1'b0;
        repeat (600) @(negedge clk);
        check("abort no_done", 64'(ndone - nd0), 64'd0);
        launch(tbl[0], "after_abort");
        drain();

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
